// File: rtl/procyon_rob_ctrl_pkg.sv
// Shared types for the reorder buffer controller and its entries.
// Entry state encodings and the controller sequencing states.
package procyon_rob_ctrl_pkg;

  typedef enum logic [1:0] {
    ROB_INVALID     = 2'b00,
    ROB_PENDING     = 2'b01,
    ROB_LSU_PENDING = 2'b10,
    ROB_RETIRABLE   = 2'b11
  } rob_entry_state_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LSU_WAIT = 2'b01,
    FLUSH    = 2'b10
  } rob_ctrl_state_t;

endpackage

// File: rtl/procyon_binary2onehot.sv
// Binary index to one-hot decoder.
// Ports: bin (IW-bit index) -> onehot (2**IW-bit vector).
module procyon_binary2onehot #(
  parameter int IW = 5
) (
  input  logic [IW-1:0]     bin,
  output logic [2**IW-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[bin] = 1'b1;
  end

endmodule

// File: rtl/procyon_rob_ctrl.sv
// ROB sequencer: head/tail/count, tag allocation, in-order retire,
// head-only LSU retire handshake and redirect flush broadcast.
// Ports: dispatch (i_dispatch_en, o_rob_stall, o_rob_tag,
// o_entry_dispatch_en), entry flags in, retire strobes out, LSU
// request/ack pair with per-entry ack steering, o_redirect flush.
module procyon_rob_ctrl
  import procyon_rob_ctrl_pkg::*;
#(
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  localparam int IW = OPTN_ROB_IDX_WIDTH,
  localparam int DEPTH = 2**OPTN_ROB_IDX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dispatch_en,
  output logic             o_rob_stall,
  output logic [IW-1:0]    o_rob_tag,
  output logic [DEPTH-1:0] o_entry_dispatch_en,
  input  logic [DEPTH-1:0] i_entry_retirable,
  input  logic [DEPTH-1:0] i_entry_lsu_pending,
  input  logic [DEPTH-1:0] i_entry_redirect,
  output logic [DEPTH-1:0] o_entry_retire_en,
  output logic             o_retire_en,
  output logic [IW-1:0]    o_retire_tag,
  output logic             o_lsu_retire_en,
  output logic [IW-1:0]    o_lsu_retire_tag,
  input  logic             i_lsu_retire_lq_ack,
  input  logic             i_lsu_retire_sq_ack,
  output logic [DEPTH-1:0] o_entry_lsu_retire_lq_ack,
  output logic [DEPTH-1:0] o_entry_lsu_retire_sq_ack,
  output logic             o_redirect
);

  localparam logic [IW:0]   CNT_FULL = (IW+1)'(DEPTH);
  localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  rob_ctrl_state_t state, state_next;
  logic [IW-1:0]    head, tail;
  logic [IW:0]      count;
  logic             redirect_q;
  logic [DEPTH-1:0] head_oh, tail_oh;
  logic             full, empty;
  logic             dispatch, retire, lsu_req;

  procyon_binary2onehot #(.IW(IW)) u_tail_oh (
    .bin    (tail),
    .onehot (tail_oh)
  );

  procyon_binary2onehot #(.IW(IW)) u_head_oh (
    .bin    (head),
    .onehot (head_oh)
  );

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign o_rob_stall = full | (state == FLUSH);
  assign dispatch    = i_dispatch_en & ~o_rob_stall;

  // Retire takes priority over an LSU request at the head: an entry
  // that is already retirable has nothing left to ask the LSU.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    lsu_req    = 1'b0;
    unique case (state)
      RUN: begin
        if (!empty) begin
          if (i_entry_retirable[head]) begin
            retire     = 1'b1;
            state_next = i_entry_redirect[head] ? FLUSH : RUN;
          end else if (i_entry_lsu_pending[head]) begin
            lsu_req    = 1'b1;
            state_next = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (i_entry_retirable[head]) begin
          retire     = 1'b1;
          state_next = i_entry_redirect[head] ? FLUSH : RUN;
        end
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign o_rob_tag           = tail;
  assign o_entry_dispatch_en = dispatch ? tail_oh : '0;
  assign o_retire_en         = retire;
  assign o_retire_tag        = head;
  assign o_entry_retire_en   = retire ? head_oh : '0;
  assign o_lsu_retire_en     = lsu_req;
  assign o_lsu_retire_tag    = head;
  assign o_redirect          = redirect_q;

  assign o_entry_lsu_retire_lq_ack =
    (state == LSU_WAIT && i_lsu_retire_lq_ack) ? head_oh : '0;
  assign o_entry_lsu_retire_sq_ack =
    (state == LSU_WAIT && i_lsu_retire_sq_ack) ? head_oh : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state      <= state_next;
      redirect_q <= (state_next == FLUSH);
      if (state == FLUSH) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (dispatch) tail <= tail + IDX_ONE;
        if (retire)   head <= head + IDX_ONE;
        unique case ({dispatch, retire})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
